video_sprite_motion_ctrl: RTL and testbench

Write-port controller placed in front of the sprite core's register/RAM write bus. It arbitrates between host (CPU) writes and an internal bounce-motion engine. Once per frame, the engine advances the sprite origin by a signed velocity, reflects off the screen edges and writes the new x_origin and y_origin to the sprite core. Host writes always pass through with priority, so sprite RAM loads and manual moves keep working.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/video_sprite_bounce.sv | 36 +++
 rtl/video_sprite_motion_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_video_sprite_motion_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared sprite-core address map and motion-engine state encoding.
package vga_pkg;

  // Sprite core register map as seen on the write bus
  localparam int SPRITE_CTRL_ADDR = 0;
  localparam int SPRITE_X_ADDR    = 4;
  localparam int SPRITE_Y_ADDR    = 8;

  // Motion engine configuration registers
  localparam logic [2:0] CFG_CTRL   = 3'd0;
  localparam logic [2:0] CFG_DX     = 3'd1;
  localparam logic [2:0] CFG_DY     = 3'd2;
  localparam logic [2:0] CFG_X_INIT = 3'd3;
  localparam logic [2:0] CFG_Y_INIT = 3'd4;

  // Bounce engine sequencing
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WR_X = 2'd2,
    ST_WR_Y = 2'd3
  } motion_state_e;

endpackage

// File: rtl/video_sprite_bounce.sv
// One-axis bounce step: advance position by a signed 8-bit velocity and
// reflect off 0 and MAX. Velocity negation wraps in 8 bits (-128 stays -128).
module video_sprite_bounce #(
  parameter int MAX   = 608,
  parameter int POS_W = 11
) (
  input  logic [POS_W-1:0] pos,
  input  logic [7:0]       vel,
  output logic [POS_W-1:0] new_pos,
  output logic [7:0]       new_vel
);

  localparam int SW = POS_W + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

  logic signed [SW-1:0] sum_s;

  assign sum_s = $signed({2'b00, pos}) + $signed({{(SW-8){vel[7]}}, vel});

  // Clamp to the screen edge and reverse direction when the step leaves the range
  always_comb begin
    new_pos = pos;
    new_vel = vel;
    if (sum_s[SW-1]) begin
      new_pos = {POS_W{1'b0}};
      new_vel = 8'd0 - vel;
    end else if (sum_s > MAX_S) begin
      new_pos = MAX_S[POS_W-1:0];
      new_vel = 8'd0 - vel;
    end else begin
      new_pos = sum_s[POS_W-1:0];
      new_vel = vel;
    end
  end

endmodule

// File: rtl/video_sprite_motion_ctrl.sv
// Write-port controller for the sprite core: host writes pass straight
// through with priority, and a per-frame bounce engine injects x/y origin
// writes in the gaps.
module video_sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int SPRITE_RAM_AW = 10,
  parameter int SPRITE_HSIZE  = 32,
  parameter int SPRITE_VSIZE  = 32,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int POS_W         = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   host_write,
  input  logic [SPRITE_RAM_AW:0] host_address,
  input  logic [31:0]            host_writedata,
  input  logic                   cfg_write,
  input  logic [2:0]             cfg_address,
  input  logic [31:0]            cfg_writedata,
  output logic                   avm_write,
  output logic [SPRITE_RAM_AW:0] avm_address,
  output logic [31:0]            avm_writedata,
  output logic                   busy
);

  localparam int BUS_AW = SPRITE_RAM_AW + 1;
  localparam int XMAX   = H_ACTIVE - SPRITE_HSIZE;
  localparam int YMAX   = V_ACTIVE - SPRITE_VSIZE;

  motion_state_e    state_r, state_nxt_s;
  logic             pending_r, pending_nxt_s, pending_s;
  logic             enable_r;
  logic [7:0]       dx_r, dy_r;
  logic [POS_W-1:0] x_r, y_r;
  logic [POS_W-1:0] wr_x_r, wr_y_r;
  logic [POS_W-1:0] calc_x_s, calc_y_s;
  logic [7:0]       calc_dx_s, calc_dy_s;

  logic              snoop_x_s, snoop_y_s;
  logic              cfg_ctrl_s, cfg_dx_s, cfg_dy_s, cfg_xi_s, cfg_yi_s;
  logic              eng_wr_s;
  logic [BUS_AW-1:0] eng_addr_s;
  logic [31:0]       eng_data_s;
  logic              avm_write_s;
  logic [BUS_AW-1:0] avm_address_s;
  logic [31:0]       avm_writedata_s;
  logic              busy_s;
  logic              unused_cfg_s;

  // Only the low POS_W bits of the config word carry position data
  assign unused_cfg_s = ^cfg_writedata[31:POS_W];

  assign snoop_x_s  = host_write && (host_address == BUS_AW'(SPRITE_X_ADDR));
  assign snoop_y_s  = host_write && (host_address == BUS_AW'(SPRITE_Y_ADDR));
  assign cfg_ctrl_s = cfg_write && (cfg_address == CFG_CTRL);
  assign cfg_dx_s   = cfg_write && (cfg_address == CFG_DX);
  assign cfg_dy_s   = cfg_write && (cfg_address == CFG_DY);
  assign cfg_xi_s   = cfg_write && (cfg_address == CFG_X_INIT);
  assign cfg_yi_s   = cfg_write && (cfg_address == CFG_Y_INIT);

  // A frame pulse in the current cycle counts as pending, so the engine starts one cycle sooner
  assign pending_s = pending_r | (frame_start & enable_r);

  video_sprite_bounce #(.MAX(XMAX), .POS_W(POS_W)) u_bounce_x (
    .pos     (x_r),
    .vel     (dx_r),
    .new_pos (calc_x_s),
    .new_vel (calc_dx_s)
  );

  video_sprite_bounce #(.MAX(YMAX), .POS_W(POS_W)) u_bounce_y (
    .pos     (y_r),
    .vel     (dy_r),
    .new_pos (calc_y_s),
    .new_vel (calc_dy_s)
  );

  // Engine sequencing: start on pending, then emit x and y writes only in host-free cycles
  always_comb begin
    state_nxt_s = state_r;
    eng_wr_s    = 1'b0;
    eng_addr_s  = {BUS_AW{1'b0}};
    eng_data_s  = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (enable_r && pending_s) state_nxt_s = ST_CALC;
        else                       state_nxt_s = ST_IDLE;
      end
      ST_CALC: begin
        state_nxt_s = ST_WR_X;
      end
      ST_WR_X: begin
        if (!host_write) begin
          eng_wr_s    = 1'b1;
          eng_addr_s  = BUS_AW'(SPRITE_X_ADDR);
          eng_data_s  = {{(32-POS_W){1'b0}}, wr_x_r};
          state_nxt_s = ST_WR_Y;
        end else begin
          state_nxt_s = ST_WR_X;
        end
      end
      ST_WR_Y: begin
        if (!host_write) begin
          eng_wr_s    = 1'b1;
          eng_addr_s  = BUS_AW'(SPRITE_Y_ADDR);
          eng_data_s  = {{(32-POS_W){1'b0}}, wr_y_r};
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR_Y;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pending queue of depth one: cleared when the update starts or the engine is disabled
  always_comb begin
    pending_nxt_s = pending_r;
    if (!enable_r) begin
      pending_nxt_s = 1'b0;
    end else if ((state_r == ST_IDLE) && pending_s) begin
      pending_nxt_s = 1'b0;
    end else if (frame_start) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Bus mux (host first) and busy, which also covers the cycle the last engine write is on the bus
  always_comb begin
    avm_write_s     = 1'b0;
    avm_address_s   = {BUS_AW{1'b0}};
    avm_writedata_s = 32'd0;
    if (host_write) begin
      avm_write_s     = 1'b1;
      avm_address_s   = host_address;
      avm_writedata_s = host_writedata;
    end else if (eng_wr_s) begin
      avm_write_s     = 1'b1;
      avm_address_s   = eng_addr_s;
      avm_writedata_s = eng_data_s;
    end else begin
      avm_write_s     = 1'b0;
    end
    busy_s = (state_nxt_s != ST_IDLE) | pending_nxt_s | eng_wr_s;
  end

  // FSM state and pending flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  // Engine datapath: host snoop beats config load beats the computed step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_r <= 1'b0;
      dx_r     <= 8'd0;
      dy_r     <= 8'd0;
      x_r      <= {POS_W{1'b0}};
      y_r      <= {POS_W{1'b0}};
      wr_x_r   <= {POS_W{1'b0}};
      wr_y_r   <= {POS_W{1'b0}};
    end else begin
      if (cfg_ctrl_s) enable_r <= cfg_writedata[0];

      if (cfg_dx_s)                  dx_r <= cfg_writedata[7:0];
      else if (state_r == ST_CALC)   dx_r <= calc_dx_s;

      if (cfg_dy_s)                  dy_r <= cfg_writedata[7:0];
      else if (state_r == ST_CALC)   dy_r <= calc_dy_s;

      if (snoop_x_s)                 x_r <= host_writedata[POS_W-1:0];
      else if (cfg_xi_s)             x_r <= cfg_writedata[POS_W-1:0];
      else if (state_r == ST_CALC)   x_r <= calc_x_s;

      if (snoop_y_s)                 y_r <= host_writedata[POS_W-1:0];
      else if (cfg_yi_s)             y_r <= cfg_writedata[POS_W-1:0];
      else if (state_r == ST_CALC)   y_r <= calc_y_s;

      // The in-flight write pair keeps its own copy so later snoops do not alter it
      if (state_r == ST_CALC) begin
        wr_x_r <= calc_x_s;
        wr_y_r <= calc_y_s;
      end
    end
  end

  // Registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avm_write     <= 1'b0;
      avm_address   <= {BUS_AW{1'b0}};
      avm_writedata <= 32'd0;
      busy          <= 1'b0;
    end else begin
      avm_write     <= avm_write_s;
      avm_address   <= avm_address_s;
      avm_writedata <= avm_writedata_s;
      busy          <= busy_s;
    end
  end

endmodule

// File: tb/tb_video_sprite_motion_ctrl.sv
// Directed bench for video_sprite_motion_ctrl: reset, host pass-through,
// exact engine timing, a table of bounce cases and multi-cycle corner cases.
module tb_video_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        host_write;
  logic [10:0] host_address;
  logic [31:0] host_writedata;
  logic        cfg_write;
  logic [2:0]  cfg_address;
  logic [31:0] cfg_writedata;
  logic        avm_write;
  logic [10:0] avm_address;
  logic [31:0] avm_writedata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] log_a[$];
  logic [31:0] log_d[$];

  typedef struct {
    logic [10:0] xi, yi;
    logic [7:0]  dx, dy;
    logic [10:0] x1, y1, x2, y2;
  } vec_t;

  vec_t vecs[6];

  video_sprite_motion_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .host_write     (host_write),
    .host_address   (host_address),
    .host_writedata (host_writedata),
    .cfg_write      (cfg_write),
    .cfg_address    (cfg_address),
    .cfg_writedata  (cfg_writedata),
    .avm_write      (avm_write),
    .avm_address    (avm_address),
    .avm_writedata  (avm_writedata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Record every write that reaches the sprite core
  always @(negedge clk) begin
    if (!rst && avm_write) begin
      log_a.push_back(avm_address);
      log_d.push_back(avm_writedata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    cfg_write = 1'b1; cfg_address = a; cfg_writedata = d;
    tick();
    cfg_write = 1'b0;
  endtask

  task automatic setup(input logic [10:0] xi, input logic [10:0] yi,
                       input logic [7:0] dx, input logic [7:0] dy);
    cfg(3'd1, {24'd0, dx});
    cfg(3'd2, {24'd0, dy});
    cfg(3'd3, {21'd0, xi});
    cfg(3'd4, {21'd0, yi});
  endtask

  task automatic pulse;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_log(input string name, input int idx,
                         input logic [10:0] a, input logic [31:0] d);
    if (idx < log_a.size()) begin
      chk({name, "_addr"}, {21'd0, log_a[idx]}, {21'd0, a});
      chk({name, "_data"}, log_d[idx], d);
    end else begin
      chk({name, "_missing"}, log_a.size(), idx + 1);
    end
  endtask

  task automatic clear_log;
    log_a.delete();
    log_d.delete();
  endtask

  initial begin
    vecs[0] = '{xi: 11'd606, yi: 11'd1,   dx: 8'd5,    dy: 8'hFC, x1: 11'd608, y1: 11'd0,   x2: 11'd603, y2: 11'd4};
    vecs[1] = '{xi: 11'd100, yi: 11'd50,  dx: 8'd3,    dy: 8'hFE, x1: 11'd103, y1: 11'd48,  x2: 11'd106, y2: 11'd46};
    vecs[2] = '{xi: 11'd2,   yi: 11'd445, dx: 8'hF9,   dy: 8'd10, x1: 11'd0,   y1: 11'd448, x2: 11'd7,   y2: 11'd438};
    vecs[3] = '{xi: 11'd608, yi: 11'd448, dx: 8'd0,    dy: 8'd0,  x1: 11'd608, y1: 11'd448, x2: 11'd608, y2: 11'd448};
    vecs[4] = '{xi: 11'd0,   yi: 11'd0,   dx: 8'h80,   dy: 8'h80, x1: 11'd0,   y1: 11'd0,   x2: 11'd0,   y2: 11'd0};
    vecs[5] = '{xi: 11'd605, yi: 11'd0,   dx: 8'd3,    dy: 8'd0,  x1: 11'd608, y1: 11'd0,   x2: 11'd608, y2: 11'd0};

    rst = 1'b1; frame_start = 1'b0; host_write = 1'b0; host_address = 11'd0;
    host_writedata = 32'd0; cfg_write = 1'b0; cfg_address = 3'd0; cfg_writedata = 32'd0;
    tick(); tick();
    chk("rst_avm_write", {31'd0, avm_write}, 32'd0);
    chk("rst_avm_addr",  {21'd0, avm_address}, 32'd0);
    chk("rst_avm_data",  avm_writedata, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Host pass-through
    host_write = 1'b1; host_address = 11'h12; host_writedata = 32'hABC;
    tick();
    host_write = 1'b0;
    chk("host_write", {31'd0, avm_write}, 32'd1);
    chk("host_addr",  {21'd0, avm_address}, 32'h12);
    chk("host_data",  avm_writedata, 32'hABC);
    chk("host_busy",  {31'd0, busy}, 32'd0);
    tick();
    chk("host_drop", {31'd0, avm_write}, 32'd0);

    // Exact engine timing: x at T+3, y at T+4, busy T+1..T+4
    cfg(3'd0, 32'd1);
    setup(11'd100, 11'd50, 8'd3, 8'hFE);
    frame_start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      frame_start = 1'b0;
      chk($sformatf("tim_wr_%0d", k), {31'd0, avm_write}, (k == 3 || k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("tim_busy_%0d", k), {31'd0, busy}, (k <= 4) ? 32'd1 : 32'd0);
      if (k == 3) begin
        chk("tim_x_addr", {21'd0, avm_address}, 32'd4);
        chk("tim_x_data", avm_writedata, 32'd103);
      end else if (k == 4) begin
        chk("tim_y_addr", {21'd0, avm_address}, 32'd8);
        chk("tim_y_data", avm_writedata, 32'd48);
      end
    end

    // Table of bounce cases, two frames each
    for (int i = 0; i < 6; i++) begin
      setup(vecs[i].xi, vecs[i].yi, vecs[i].dx, vecs[i].dy);
      clear_log();
      pulse();
      wait_idle($sformatf("vec%0d_f1", i));
      pulse();
      wait_idle($sformatf("vec%0d_f2", i));
      chk($sformatf("vec%0d_count", i), log_a.size(), 4);
      chk_log($sformatf("vec%0d_x1", i), 0, 11'd4, {21'd0, vecs[i].x1});
      chk_log($sformatf("vec%0d_y1", i), 1, 11'd8, {21'd0, vecs[i].y1});
      chk_log($sformatf("vec%0d_x2", i), 2, 11'd4, {21'd0, vecs[i].x2});
      chk_log($sformatf("vec%0d_y2", i), 3, 11'd8, {21'd0, vecs[i].y2});
    end

    // Host holds the bus across the engine's write slots
    setup(11'd100, 11'd50, 8'd3, 8'hFE);
    clear_log();
    pulse();
    tick();
    for (int k = 0; k < 3; k++) begin
      host_write = 1'b1; host_address = 11'h20; host_writedata = 32'h100 + k;
      tick();
    end
    host_write = 1'b0;
    wait_idle("hold");
    chk("hold_count", log_a.size(), 5);
    for (int k = 0; k < 3; k++)
      chk_log($sformatf("hold_host%0d", k), k, 11'h20, 32'h100 + k);
    chk_log("hold_x", 3, 11'd4, 32'd103);
    chk_log("hold_y", 4, 11'd8, 32'd48);

    // Pulses two cycles apart queue one update; a third after idle adds one more
    setup(11'd10, 11'd10, 8'd1, 8'd1);
    clear_log();
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    wait_idle("queue_a");
    pulse();
    wait_idle("queue_b");
    chk("queue_count", log_a.size(), 6);
    for (int k = 0; k < 3; k++) begin
      chk_log($sformatf("queue_x%0d", k), 2 * k,     11'd4, 32'd11 + k);
      chk_log($sformatf("queue_y%0d", k), 2 * k + 1, 11'd8, 32'd11 + k);
    end

    // Disabled engine ignores frame_start
    cfg(3'd0, 32'd0);
    clear_log();
    pulse();
    repeat (8) tick();
    chk("dis_count", log_a.size(), 0);
    chk("dis_busy", {31'd0, busy}, 32'd0);

    // Host snoop of x during WR_X: pair completes, next frame starts from host value
    cfg(3'd0, 32'd1);
    setup(11'd100, 11'd50, 8'd3, 8'd0);
    clear_log();
    pulse();
    tick();
    host_write = 1'b1; host_address = 11'd4; host_writedata = 32'd200;
    tick();
    host_write = 1'b0;
    wait_idle("snoop_a");
    pulse();
    wait_idle("snoop_b");
    chk("snoop_count", log_a.size(), 5);
    chk_log("snoop_host", 0, 11'd4, 32'd200);
    chk_log("snoop_x1",   1, 11'd4, 32'd103);
    chk_log("snoop_y1",   2, 11'd8, 32'd50);
    chk_log("snoop_x2",   3, 11'd4, 32'd203);
    chk_log("snoop_y2",   4, 11'd8, 32'd50);

    // Reset in the middle of an update drops the pair
    pulse();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_write", {31'd0, avm_write}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    clear_log();
    repeat (8) tick();
    chk("mid_rst_count", log_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
